// File: rtl/fifo_level_pkg.sv
// Shared types and helpers for the level-tracking 1R1W FIFO.
// Holds the priming/run state encoding and the depth calculation.
package fifo_level_pkg;

   typedef enum logic [0:0] {
      PRIME = 1'b0,
      RUN   = 1'b1
   } fifo_state_e;

   localparam int unsigned fifo_min_depth_log2_c = 32'd1;
   localparam int unsigned fifo_max_depth_log2_c = 32'd10;

   function automatic int unsigned fifo_depth(input int unsigned depth_log2);
      return 32'd1 << depth_log2;
   endfunction

endpackage

// File: rtl/ram_1r1w_async.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the FIFO pointers define which entries are live.
module ram_1r1w_async
   import fifo_level_pkg::*;
#(
   parameter int unsigned width_p      = 32'd25,
   parameter int unsigned depth_log2_p = 32'd3
)(
   input  logic                    clk_i,
   input  logic                    w_v_i,
   input  logic [depth_log2_p-1:0] w_addr_i,
   input  logic [width_p-1:0]      w_data_i,
   input  logic [depth_log2_p-1:0] r_addr_i,
   output logic [width_p-1:0]      r_data_o
);

   localparam int unsigned depth_lp = fifo_depth(depth_log2_p);

   logic [width_p-1:0] mem_r [0:depth_lp-1];

   // Write port: capture data on the rising edge when the write strobe is high.
   always_ff @(posedge clk_i) begin
      if (w_v_i) begin
         mem_r[w_addr_i] <= w_data_i;
      end
   end

   assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/fifo_1r1w_level.sv
// 1-read/1-write FIFO with occupancy count, almost-full/empty flags, flush and a
// priming mode that withholds output until a fill level is reached.
module fifo_1r1w_level
   import fifo_level_pkg::*;
#(
   parameter int unsigned width_p       = 32'd25,
   parameter int unsigned depth_log2_p  = 32'd3,
   parameter int unsigned prime_level_p = 32'd4,
   parameter int unsigned af_level_p    = 32'd6,
   parameter int unsigned ae_level_p    = 32'd1,
   parameter int unsigned rearm_p       = 32'd1
)(
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    flush_i,
   input  logic [width_p-1:0]      data_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   output logic [width_p-1:0]      data_o,
   output logic                    valid_o,
   input  logic                    yumi_i,
   output logic [depth_log2_p:0]   count_o,
   output logic                    almost_full_o,
   output logic                    almost_empty_o,
   output logic                    underrun_o
);

   localparam int unsigned depth_lp = fifo_depth(depth_log2_p);
   localparam int unsigned cw_lp    = depth_log2_p + 32'd1;

   localparam bit prime_en_lp = (prime_level_p != 32'd0);
   localparam bit rearm_lp    = (rearm_p != 32'd0);

   // prime_m1 lets "count >= prime" be written as "count > prime-1" without a compare against zero.
   localparam logic [cw_lp-1:0] prime_m1_lp = prime_en_lp ? cw_lp'(prime_level_p - 32'd1) : '0;
   localparam logic [cw_lp-1:0] af_lvl_lp   = cw_lp'(af_level_p);
   localparam logic [cw_lp-1:0] ae_lvl_lp   = cw_lp'(ae_level_p);
   localparam logic [cw_lp-1:0] one_lp      = cw_lp'(32'd1);

   localparam fifo_state_e init_state_lp = prime_en_lp ? PRIME : RUN;

   if ((depth_log2_p < fifo_min_depth_log2_c) || (depth_log2_p > fifo_max_depth_log2_c)) begin : g_bad_depth
      $error("fifo_1r1w_level: depth_log2_p out of range 1..10");
   end
   if (prime_level_p > depth_lp) begin : g_bad_prime
      $error("fifo_1r1w_level: prime_level_p exceeds depth");
   end
   if ((af_level_p < 32'd1) || (af_level_p > depth_lp)) begin : g_bad_af
      $error("fifo_1r1w_level: af_level_p out of range 1..depth");
   end
   if (ae_level_p > (depth_lp - 32'd1)) begin : g_bad_ae
      $error("fifo_1r1w_level: ae_level_p out of range 0..depth-1");
   end
   if (rearm_p > 32'd1) begin : g_bad_rearm
      $error("fifo_1r1w_level: rearm_p must be 0 or 1");
   end

   logic [cw_lp-1:0] wr_ptr_r, rd_ptr_r, count_r;
   logic [cw_lp-1:0] wr_ptr_s, rd_ptr_s, count_s;
   fifo_state_e      state_r, state_s;
   logic             ready_r, valid_r, af_r, ae_r, underrun_r;
   logic             ready_s, valid_s, af_s, ae_s, underrun_s;
   logic             enq_s, deq_s, w_v_s, empty_s, full_s, prime_hit_s;

   assign enq_s = valid_i & ready_r;
   assign deq_s = yumi_i & valid_r;
   assign w_v_s = enq_s & ~flush_i & ~reset_i;

   // Next-state: pointers, count, priming FSM and every registered status flag.
   always_comb begin
      wr_ptr_s    = wr_ptr_r + {{depth_log2_p{1'b0}}, enq_s};
      rd_ptr_s    = rd_ptr_r + {{depth_log2_p{1'b0}}, deq_s};
      count_s     = count_r + {{depth_log2_p{1'b0}}, enq_s} - {{depth_log2_p{1'b0}}, deq_s};
      prime_hit_s = !prime_en_lp || (count_r > prime_m1_lp);
      state_s     = state_r;
      underrun_s  = 1'b0;

      case (state_r)
         PRIME: begin
            if (prime_hit_s) begin
               state_s = RUN;
            end else begin
               state_s = PRIME;
            end
         end
         RUN: begin
            if (rearm_lp && (count_r == one_lp) && deq_s && !enq_s) begin
               state_s    = PRIME;
               underrun_s = 1'b1;
            end else begin
               state_s = RUN;
            end
         end
         default: begin
            state_s = init_state_lp;
         end
      endcase

      empty_s = (wr_ptr_s == rd_ptr_s);
      full_s  = (wr_ptr_s[cw_lp-1] != rd_ptr_s[cw_lp-1]) &&
                (wr_ptr_s[cw_lp-2:0] == rd_ptr_s[cw_lp-2:0]);
      ready_s = !full_s;
      valid_s = !empty_s && (state_s == RUN);
      af_s    = (count_s >= af_lvl_lp);
      ae_s    = (count_s <= ae_lvl_lp);
   end

   // State registers; reset and flush clear the FIFO identically.
   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         state_r    <= init_state_lp;
         ready_r    <= 1'b1;
         valid_r    <= 1'b0;
         af_r       <= 1'b0;
         ae_r       <= 1'b1;
         underrun_r <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_s;
         rd_ptr_r   <= rd_ptr_s;
         count_r    <= count_s;
         state_r    <= state_s;
         ready_r    <= ready_s;
         valid_r    <= valid_s;
         af_r       <= af_s;
         ae_r       <= ae_s;
         underrun_r <= underrun_s;
      end
   end

   ram_1r1w_async #(
      .width_p      (width_p),
      .depth_log2_p (depth_log2_p)
   ) u_ram (
      .clk_i    (clk_i),
      .w_v_i    (w_v_s),
      .w_addr_i (wr_ptr_r[depth_log2_p-1:0]),
      .w_data_i (data_i),
      .r_addr_i (rd_ptr_r[depth_log2_p-1:0]),
      .r_data_o (data_o)
   );

   assign ready_o        = ready_r;
   assign valid_o        = valid_r;
   assign count_o        = count_r;
   assign almost_full_o  = af_r;
   assign almost_empty_o = ae_r;
   assign underrun_o     = underrun_r;

endmodule

// File: doc/fifo_1r1w_level.md
Name: fifo_1r1w_level

Overview:
- Parametrised successor to the plain 1-read/1-write ready/valid FIFO used between the I2S2 AXIS receive and transmit ports.
- Adds:
  - configurable depth
  - an occupancy count
  - almost-full and almost-empty flags
  - a synchronous flush
  - a priming mode that withholds output until a fill level is reached, then re-primes after an underrun.
- Sits between the axis_rx producer (valid/ready) and the axis_tx consumer (valid/yumi), so audio playback starts with a cushion of buffered samples.

Parameters:
- width_p, 25, data bits per entry (24-bit sample + last flag).
- depth_log2_p, 3, depth = 2**depth_log2_p entries; legal range 1..10.
- prime_level_p, 4, entries required before valid_o first asserts; 0 disables priming; must be <= depth.
- af_level_p, 6, almost_full_o threshold; 1..depth.
- ae_level_p, 1, almost_empty_o threshold; 0..depth-1.
- rearm_p, 1, 1 = return to priming on underrun; 0 = prime once after reset/flush only.

Ports:
- clk_i  in  1  single clock, all state on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous empty; same effect as reset on datapath and FSM.
- data_i  in  width_p  write data.
- valid_i  in  1  producer has data.
- ready_o  out  1  FIFO can accept; enqueue = valid_i & ready_o.
- data_o  out  width_p  head entry; meaningful only when valid_o is high.
- valid_o  out  1  head available to consumer.
- yumi_i  in  1  consumer takes head this cycle; legal only when valid_o is high.
- count_o  out  depth_log2_p+1  current occupancy, 0..depth.
- almost_full_o  out  1  count_o >= af_level_p.
- almost_empty_o  out  1  count_o <= ae_level_p.
- underrun_o  out  1  one-cycle pulse on a RUN->PRIME transition.

Behaviour:
- Reset (reset_i=1 at a clock edge):
  - wr_ptr, rd_ptr and count cleared to 0.
  - State goes to PRIME, or RUN if prime_level_p==0.
  - Outputs after reset: ready_o=1, valid_o=0, count_o=0, almost_full_o=0, almost_empty_o=1, underrun_o=0.
  - Memory contents are not reset.
- Pointers are depth_log2_p+1 bits.
  - Full when the MSBs differ and the low bits are equal.
  - Empty when the pointers are equal.
  - Wrap-around is natural modulo 2**(depth_log2_p+1).
- ready_o = !full.
  - Depends only on registered state; there is no combinational path from yumi_i.
  - When full, an enqueue is refused even if yumi_i is high the same cycle.
- valid_o = !empty & (state==RUN).
  - data_o = mem[rd_ptr low bits], asynchronous read.
  - Zero-latency head: data written at edge N is visible on data_o after edge N.
- Dequeue = yumi_i & valid_o. yumi_i while valid_o is low is ignored; no pointer change, no underflow.
- Count update: count_next = count + enq - deq.
  - Simultaneous enqueue and dequeue leaves count unchanged and advances both pointers.
- FSM, evaluated on the registered count:
  - PRIME -> RUN when count >= prime_level_p. valid_o rises the cycle after the priming write lands.
  - RUN -> PRIME when rearm_p==1, count==1, deq==1, enq==0; underrun_o pulses that same next cycle.
  - With rearm_p==0, the FIFO stays in RUN and simply reports empty (valid_o=0).
- Flush:
  - flush_i has priority over enq/deq in the same cycle; both are discarded.
  - Result matches reset, except underrun_o stays 0.
  - Reset has priority over flush.
- Thresholds are pure compares on the count register, so they are glitch-free registered-derived outputs.
- Illegal parameters (prime_level_p > depth, af_level_p out of range) are caught by elaboration-time assertions.

Decomposition:
- Package fifo_level_pkg:
  - state enum {PRIME, RUN}, 1 bit.
  - Function computing depth from depth_log2_p.
- Sub-module ram_1r1w_async (width_p, depth_log2_p):
  - Synchronous write port (w_v_i, w_addr_i, w_data_i).
  - Asynchronous read port (r_addr_i, r_data_o).
  - Holds storage only; pointers, FSM and flags stay in fifo_1r1w_level.

Test Plan (width_p=25, depth_log2_p=3 giving depth 8, prime 4, af 6, ae 1, rearm 1 unless stated):
1. Reset, then push 0x000001..0x000003 with yumi_i=0 -> valid_o stays 0, count_o=3, almost_empty_o=0 after the second push. Push 0x000004 -> valid_o=1 next cycle, data_o=0x000001.
2. Push 8 words without yumi -> ready_o=0 at count 8, almost_full_o=1 from count 6. A 9th valid_i with simultaneous yumi_i is not enqueued: count goes 8->7.
3. Steady state at count 5, valid_i=yumi_i=1 for 20 cycles with an incrementing pattern -> count stays 5, output order exact, pointer wrap exercised twice.
4. Drain to empty with no writes -> underrun_o pulses once at 1->0, and valid_o stays 0. Refill 3 words -> still 0. 4th word -> valid_o=1.
5. At count 5, assert flush_i with valid_i=1 and yumi_i=1 -> next cycle count_o=0, ready_o=1, valid_o=0, underrun_o=0, and no data leaks out.
6. prime_level_p=0, rearm_p=0: a single push of 0x1ABCDEF -> valid_o=1 on the next cycle. Dequeue -> empty; underrun_o never pulses.
